// File: rtl/data_io_port_if.sv
// CPU-side and peripheral-side signal bundle for data_io_port.
// The slave modport is the port itself; the master modport is the driver.
interface data_io_port_if #(
  parameter int RX_DEPTH = 4
);
  localparam int CW = $clog2(RX_DEPTH) + 1;

  logic          store;
  logic [2:0]    data_type;
  logic [1:0]    data_offset;
  logic [31:0]   store_data;
  logic          store_busy;
  logic          load;
  logic [31:0]   load_data;
  logic [CW-1:0] rx_count;
  logic          misalign_err;
  logic [31:0]   tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [31:0]   rx_data;
  logic          rx_valid;
  logic          rx_ready;

  modport master (
    output store, data_type, data_offset,
    output store_data, load, tx_ready,
    output rx_data, rx_valid,
    input  store_busy, load_data, rx_count,
    input  misalign_err, tx_data, tx_valid,
    input  rx_ready
  );

  modport slave (
    input  store, data_type, data_offset,
    input  store_data, load, tx_ready,
    input  rx_data, rx_valid,
    output store_busy, load_data, rx_count,
    output misalign_err, tx_data, tx_valid,
    output rx_ready
  );
endinterface

// File: rtl/data_io_port.sv
// Peripheral endpoint: lane-merged TX store path
// and a small RX FIFO popped by CPU loads.
module data_io_port #(
  parameter int RX_DEPTH = 4
) (
  input logic           clock,
  input logic           reset_n,
  data_io_port_if.slave io
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(RX_DEPTH);

  logic [31:0]   staging;
  logic [31:0]   merged;
  logic          legal;
  logic          accept;
  logic          is_b, is_h, is_w, is_r;
  logic [31:0]   tx_data_q;
  logic          tx_valid_q;
  logic          err_q;
  logic [31:0]   mem [RX_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          push, pop;

  assign is_b = io.data_type[1:0] == 2'b00;
  assign is_h = io.data_type[1:0] == 2'b01;
  assign is_w = io.data_type[1:0] == 2'b10;
  assign is_r = io.data_type[1:0] == 2'b11;

  assign io.store_busy = tx_valid_q && !io.tx_ready;
  assign accept = io.store && !io.store_busy;

  // Replace the addressed lanes and judge alignment.
  always_comb begin
    merged = staging;
    legal  = 1'b0;
    unique case (1'b1)
      is_b: begin
        legal = 1'b1;
        merged[{io.data_offset, 3'b000} +: 8] =
          io.store_data[7:0];
      end
      is_h: begin
        legal = !io.data_offset[0];
        merged[{io.data_offset[1], 4'b0000} +: 16] =
          io.store_data[15:0];
      end
      is_w: begin
        legal  = io.data_offset == 2'b00;
        merged = io.store_data;
      end
      is_r: legal = 1'b0;
    endcase
  end

  // Staging word, TX holding register and sticky error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      staging    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept && legal) begin
        staging    <= merged;
        tx_data_q  <= merged;
        tx_valid_q <= 1'b1;
      end else if (tx_valid_q && io.tx_ready) begin
        tx_valid_q <= 1'b0;
      end
      if (accept && !legal) err_q <= 1'b1;
    end
  end

  assign io.tx_data      = tx_data_q;
  assign io.tx_valid     = tx_valid_q;
  assign io.misalign_err = err_q;

  assign io.rx_ready = count < FULL;
  assign push = io.rx_valid && io.rx_ready;
  assign pop  = io.load && count != '0;

  // FIFO storage needs no reset; occupancy gates reads.
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= io.rx_data;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io.rx_count  = count;
  assign io.load_data = count != '0 ? mem[rp] : '0;
endmodule
